// File: rtl/corelet_ctrl_if.sv
// Control bundle between the corelet controller and the SRAM/L0/MAC/OFIFO datapath.
interface corelet_ctrl_if #(
    parameter int row     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36
);
    logic                               start;
    logic                               ofifo_valid;
    logic                               busy;
    logic                               done;
    logic                               w_cen;
    logic [$clog2(len_kij*row)-1:0]     w_addr;
    logic                               l0_wr;
    logic                               l0_rd;
    logic [1:0]                         inst_w;
    logic                               act_cen;
    logic [$clog2(len_nij)-1:0]         act_addr;
    logic                               act_valid;
    logic                               ofifo_rd;
    logic                               psum_cen;
    logic [$clog2(len_nij)-1:0]         psum_addr;
    logic                               old_psum_valid;
    logic [$clog2(len_kij)-1:0]         kij;

    modport master (
        input  start, ofifo_valid,
        output busy, done, w_cen, w_addr, l0_wr, l0_rd, inst_w, act_cen, act_addr,
               act_valid, ofifo_rd, psum_cen, psum_addr, old_psum_valid, kij
    );

    modport slave (
        output start, ofifo_valid,
        input  busy, done, w_cen, w_addr, l0_wr, l0_rd, inst_w, act_cen, act_addr,
               act_valid, ofifo_rd, psum_cen, psum_addr, old_psum_valid, kij
    );
endinterface

// File: rtl/corelet_ctrl.sv
// Layer sequencer: per kernel position fetch weights, load PEs, stream activations, drain psums.
// Outputs are registered and aligned with the state; DRAIN pops in the same cycle ofifo_valid is seen and stalls indefinitely while it is low.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36
) (
    input  logic            clk,
    input  logic            reset,
    corelet_ctrl_if.master  bus
);
    localparam int WA_W    = $clog2(len_kij*row);
    localparam int AA_W    = $clog2(len_nij);
    localparam int K_W     = $clog2(len_kij);
    localparam int CNT_TOP = (row + col > len_nij + 1) ? row + col : len_nij + 1;
    localparam int C_W     = $clog2(CNT_TOP);

    typedef enum logic [2:0] {IDLE, W_FETCH, W_LOAD, EXEC, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [C_W-1:0]    cnt_q, cnt_d;
    logic [K_W-1:0]    kij_q, kij_d;
    logic [AA_W-1:0]   pops_q, pops_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              w_cen_q, w_cen_d;
    logic [WA_W-1:0]   w_addr_q, w_addr_d;
    logic              l0_wr_q, l0_wr_d;
    logic              l0_rd_q, l0_rd_d;
    logic [1:0]        inst_w_q, inst_w_d;
    logic              act_cen_q, act_cen_d;
    logic [AA_W-1:0]   act_addr_q, act_addr_d;
    logic              act_valid_q, act_valid_d;
    logic              old_psum_valid_q, old_psum_valid_d;

    logic              pop;
    logic              psum_cen;
    logic              w_fetch;
    logic              act_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        pops_d  = pops_q;
        pop     = (state_q == DRAIN) && bus.ofifo_valid && (32'(pops_q) < len_nij);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = W_FETCH;
                    cnt_d   = '0;
                    kij_d   = '0;
                end
            end
            W_FETCH: begin
                if (32'(cnt_q) == row) begin
                    state_d = W_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            W_LOAD: begin
                if (32'(cnt_q) == row + col - 1) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            EXEC: begin
                if (32'(cnt_q) == len_nij) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    pops_d  = '0;
                end else begin
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            DRAIN: begin
                // pop count survives ofifo_valid gaps; leave right after the last pop
                if (pop) begin
                    if (32'(pops_q) == len_nij - 1) begin
                        pops_d = '0;
                        if (32'(kij_q) == len_kij - 1) begin
                            state_d = DONE;
                        end else begin
                            state_d = W_FETCH;
                            kij_d   = kij_q + K_W'(1);
                        end
                    end else begin
                        pops_d = pops_q + AA_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                kij_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // The first pass has nothing to accumulate onto, so psum SRAM stays idle.
    assign psum_cen = ~(pop && (kij_q != '0));

    always_comb begin
        w_fetch          = (state_d == W_FETCH) && (32'(cnt_d) < row);
        act_rd           = (state_d == EXEC) && (32'(cnt_d) < len_nij);
        busy_d           = (state_d != IDLE);
        done_d           = (state_d == DONE);
        w_cen_d          = ~w_fetch;
        w_addr_d         = w_fetch ? WA_W'(32'(kij_d) * row + 32'(cnt_d)) : '0;
        l0_wr_d          = ~w_cen_q;
        l0_rd_d          = (state_d == W_LOAD) && (32'(cnt_d) < row);
        act_cen_d        = ~act_rd;
        act_addr_d       = act_rd ? AA_W'(cnt_d) : '0;
        act_valid_d      = ~act_cen_q;
        inst_w_d         = (state_d == W_LOAD) ? 2'b01 : (act_valid_d ? 2'b10 : 2'b00);
        old_psum_valid_d = ~psum_cen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            kij_q            <= '0;
            pops_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            w_cen_q          <= 1'b1;
            w_addr_q         <= '0;
            l0_wr_q          <= 1'b0;
            l0_rd_q          <= 1'b0;
            inst_w_q         <= 2'b00;
            act_cen_q        <= 1'b1;
            act_addr_q       <= '0;
            act_valid_q      <= 1'b0;
            old_psum_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            kij_q            <= kij_d;
            pops_q           <= pops_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            w_cen_q          <= w_cen_d;
            w_addr_q         <= w_addr_d;
            l0_wr_q          <= l0_wr_d;
            l0_rd_q          <= l0_rd_d;
            inst_w_q         <= inst_w_d;
            act_cen_q        <= act_cen_d;
            act_addr_q       <= act_addr_d;
            act_valid_q      <= act_valid_d;
            old_psum_valid_q <= old_psum_valid_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.w_cen          = w_cen_q;
    assign bus.w_addr         = w_addr_q;
    assign bus.l0_wr          = l0_wr_q;
    assign bus.l0_rd          = l0_rd_q;
    assign bus.inst_w         = inst_w_q;
    assign bus.act_cen        = act_cen_q;
    assign bus.act_addr       = act_addr_q;
    assign bus.act_valid      = act_valid_q;
    assign bus.ofifo_rd       = pop;
    assign bus.psum_cen       = psum_cen;
    assign bus.psum_addr      = pops_q;
    assign bus.old_psum_valid = old_psum_valid_q;
    assign bus.kij            = kij_q;
endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: full layer with OFIFO gaps, mid-layer reset, ignored starts.
module tb_corelet_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    corelet_ctrl_if #(.row(8), .len_kij(9), .len_nij(36)) bus ();

    corelet_ctrl #(.row(8), .col(8), .len_kij(9), .len_nij(36)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int bursts, exp_waddr, waddr_err, done_cnt, pops, psum_reads, l0wr_p0, l0wr_err;
        int opv_p0, opv_err, rd_no_vld, pops_p1, gaps_p1, paddr_err, mutex_err, kij_err;
        int load_cyc, l0rd_cyc, actv_cyc, inst10_err, psum_no_rd, found, busy_cyc, pulsed;
        logic prev_wcen, prev_pcen, last_busy;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.ofifo_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_w_cen",    32'(bus.w_cen),    32'd1);
        check("rst_act_cen",  32'(bus.act_cen),  32'd1);
        check("rst_psum_cen", 32'(bus.psum_cen), 32'd1);
        check("rst_inst_w",   32'(bus.inst_w),   32'd0);
        check("rst_done",     32'(bus.done),     32'd0);

        // start and reset together: reset wins
        bus.start = 1'b1;
        reset = 1'b1;
        tick();
        bus.start = 1'b0;
        reset = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        tick();
        check("rst_start_idle", 32'(bus.busy), 32'd0);

        // full layer; OFIFO valid toggles 1,0,0,1 during the kij=1 pass
        bus.ofifo_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("first_w_cen",  32'(bus.w_cen),  32'd0);
        check("first_w_addr", 32'(bus.w_addr), 32'd0);
        check("first_busy",   32'(bus.busy),   32'd1);
        bursts = 0; exp_waddr = 0; waddr_err = 0; done_cnt = 0; pops = 0; psum_reads = 0;
        l0wr_p0 = 0; l0wr_err = 0; opv_p0 = 0; opv_err = 0; rd_no_vld = 0; pops_p1 = 0;
        gaps_p1 = 0; paddr_err = 0; mutex_err = 0; kij_err = 0; load_cyc = 0; l0rd_cyc = 0;
        actv_cyc = 0; inst10_err = 0; psum_no_rd = 0;
        prev_wcen = 1'b1;
        prev_pcen = 1'b1;
        last_busy = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bus.ofifo_valid = (bursts == 2) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            #1;
            last_busy = bus.busy;
            if (!bus.busy) break;
            if (prev_wcen && !bus.w_cen) bursts++;
            if (!bus.w_cen) begin
                if (32'(bus.w_addr) != exp_waddr) waddr_err++;
                exp_waddr++;
            end
            if (bus.l0_wr != ~prev_wcen) l0wr_err++;
            if (bus.l0_wr && bursts == 1) l0wr_p0++;
            if (bus.old_psum_valid != ~prev_pcen) opv_err++;
            if (bus.old_psum_valid && bursts == 1) opv_p0++;
            if (bus.ofifo_rd && !bus.ofifo_valid) rd_no_vld++;
            if (!bus.psum_cen && !bus.ofifo_rd) psum_no_rd++;
            if (bus.ofifo_rd) begin
                if (32'(bus.psum_addr) != pops % 36) paddr_err++;
                pops++;
                if (bursts == 2) pops_p1++;
            end
            if (bursts == 2 && pops_p1 > 0 && pops_p1 < 36 && !bus.ofifo_valid) gaps_p1++;
            if (!bus.psum_cen) psum_reads++;
            if (bus.done) done_cnt++;
            if (32'(bus.l0_wr) + 32'(bus.act_valid) + 32'(bus.ofifo_rd) > 1) mutex_err++;
            if (32'(bus.kij) != bursts - 1) kij_err++;
            if (bus.inst_w == 2'b01) load_cyc++;
            if (bus.l0_rd) l0rd_cyc++;
            if (bus.act_valid) actv_cyc++;
            if ((bus.inst_w == 2'b10) != bus.act_valid) inst10_err++;
            prev_wcen = bus.w_cen;
            prev_pcen = bus.psum_cen;
            @(posedge clk);
            #1;
        end
        check("layer_ended",     32'(last_busy), 32'd0);
        check("w_bursts",        bursts,         32'd9);
        check("w_addr_count",    exp_waddr,      32'd72);
        check("w_addr_order",    waddr_err,      32'd0);
        check("done_once",       done_cnt,       32'd1);
        check("pops_total",      pops,           32'd324);
        check("psum_reads",      psum_reads,     32'd288);
        check("l0_wr_pass0",     l0wr_p0,        32'd8);
        check("l0_wr_lag",       l0wr_err,       32'd0);
        check("old_psum_pass0",  opv_p0,         32'd0);
        check("old_psum_lag",    opv_err,        32'd0);
        check("rd_without_vld",  rd_no_vld,      32'd0);
        check("psum_without_rd", psum_no_rd,     32'd0);
        check("pops_gap_pass",   pops_p1,        32'd36);
        check("gaps_seen",       32'(gaps_p1 > 0), 32'd1);
        check("psum_addr_seq",   paddr_err,      32'd0);
        check("one_hot_strobes", mutex_err,      32'd0);
        check("kij_track",       kij_err,        32'd0);
        check("load_cycles",     load_cyc,       32'd144);
        check("l0_rd_cycles",    l0rd_cyc,       32'd72);
        check("act_valid_cyc",   actv_cyc,       32'd324);
        check("inst_exec_match", inst10_err,     32'd0);

        // reset mid-EXEC at act_addr 17
        bus.ofifo_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 0;
        for (int c = 0; c < 500; c++) begin
            if (!bus.act_cen && bus.act_addr == 6'd17) begin
                found = 1;
                break;
            end
            tick();
        end
        check("exec_addr17_seen", found, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy",      32'(bus.busy),      32'd0);
        check("midrst_act_cen",   32'(bus.act_cen),   32'd1);
        check("midrst_inst_w",    32'(bus.inst_w),    32'd0);
        check("midrst_act_valid", 32'(bus.act_valid), 32'd0);
        check("midrst_kij",       32'(bus.kij),       32'd0);
        tick();
        check("midrst_idle", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_w_cen",  32'(bus.w_cen),  32'd0);
        check("restart_w_addr", 32'(bus.w_addr), 32'd0);
        check("restart_kij",    32'(bus.kij),    32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // start pulsed during W_LOAD must not disturb the layer: 9*98 + DONE busy cycles
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        pulsed = 0;
        for (int c = 0; c < 3000; c++) begin
            last_busy = bus.busy;
            if (!bus.busy) break;
            busy_cyc++;
            if (bus.done) done_cnt++;
            bus.start = (pulsed == 0) && (bus.inst_w == 2'b01);
            if (bus.start) pulsed = 1;
            tick();
        end
        bus.start = 1'b0;
        check("wload_start_sent", pulsed,          32'd1);
        check("wload_ended",      32'(last_busy),  32'd0);
        check("wload_busy_cyc",   busy_cyc,        32'd883);
        check("wload_done_once",  done_cnt,        32'd1);
        tick();
        check("wload_stays_idle", 32'(bus.busy),   32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
